// File: rtl/bram_bus_arbiter_pkg.sv
// Shared definitions for bram_bus_arbiter: FSM state encodings, master ids and the
// BRAM window end derivation used by the address decoder.
package bram_bus_arbiter_pkg;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StResp   = 2'd2;
    localparam logic [1:0] StFault  = 2'd3;

    localparam logic MasterCpu = 1'b0;
    localparam logic MasterAux = 1'b1;

    // Exclusive end of the window, kept in 33 bits so a window ending at 4 GiB does not wrap.
    function automatic logic [32:0] bram_window_end(input logic [31:0] base,
                                                    input int unsigned words);
        return {1'b0, base} + (33'(words) << 2);
    endfunction

endpackage

// File: rtl/bram_bus_arbiter_addr_decode.sv
// Combinational BRAM window check and byte-to-word address extraction.
module bram_bus_arbiter_addr_decode
    import bram_bus_arbiter_pkg::*;
#(
    parameter int unsigned BRAM_WORDS      = 8192,
    parameter int unsigned BRAM_ADDR_WIDTH = $clog2(BRAM_WORDS),
    parameter logic [31:0] BRAM_BASE       = 32'h0000_0000
) (
    input  logic [31:0]                addr_i,
    output logic                       in_window_o,
    output logic [BRAM_ADDR_WIDTH-1:0] word_addr_o
);

    localparam logic [32:0] WindowEnd = bram_window_end(BRAM_BASE, BRAM_WORDS);

    assign in_window_o = (addr_i >= BRAM_BASE) && ({1'b0, addr_i} < WindowEnd);

    // addr[1:0] is dropped here; byte lanes come from wstrb alone.
    assign word_addr_o = BRAM_ADDR_WIDTH'((addr_i - BRAM_BASE) >> 2);

endmodule

// File: rtl/bram_bus_arbiter.sv
// Two-master arbiter/sequencer for the single-port BRAM. Tie resolution is fixed priority
// (m0 wins) unless ARB_ROUND_ROBIN_EN is defined, which alternates grants on ties.
module bram_bus_arbiter
    import bram_bus_arbiter_pkg::*;
#(
    parameter int unsigned BRAM_WORDS      = 8192,
    parameter int unsigned BRAM_ADDR_WIDTH = $clog2(BRAM_WORDS),
    parameter logic [31:0] BRAM_BASE       = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       m0_valid,
    input  logic [31:0]                m0_addr,
    input  logic [31:0]                m0_wdata,
    input  logic [3:0]                 m0_wstrb,
    output logic                       m0_ready,
    output logic [31:0]                m0_rdata,
    output logic                       m0_fault,

    input  logic                       m1_valid,
    input  logic [31:0]                m1_addr,
    input  logic [31:0]                m1_wdata,
    input  logic [3:0]                 m1_wstrb,
    output logic                       m1_ready,
    output logic [31:0]                m1_rdata,
    output logic                       m1_fault,

    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]                bram_wdata,
    output logic [3:0]                 bram_wmask,
    input  logic [31:0]                bram_rdata,

    output logic                       busy
);

    logic [1:0]                 state_q, state_d;
    logic                       grant_q, grant_d;
    logic [BRAM_ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
    logic [31:0]                wdata_q, wdata_d;
    logic [3:0]                 wstrb_q, wstrb_d;

    logic                       any_valid;
    logic                       tie_pick;
    logic                       win_id;
    logic [31:0]                win_addr;
    logic                       win_in_window;
    logic [BRAM_ADDR_WIDTH-1:0] win_word_addr;

    assign any_valid = m0_valid | m1_valid;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // Reset value points at m1 so the first tie after reset goes to m0.
    assign tie_pick = ~last_grant_q;

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == StIdle && any_valid) begin
            last_grant_d = win_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= MasterAux;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign tie_pick = MasterCpu;
`endif

    always_comb begin
        win_id = MasterCpu;
        if (m0_valid && m1_valid) begin
            win_id = tie_pick;
        end else if (m1_valid) begin
            win_id = MasterAux;
        end
    end

    assign win_addr = (win_id == MasterAux) ? m1_addr : m0_addr;

    bram_bus_arbiter_addr_decode #(
        .BRAM_WORDS      (BRAM_WORDS),
        .BRAM_ADDR_WIDTH (BRAM_ADDR_WIDTH),
        .BRAM_BASE       (BRAM_BASE)
    ) u_addr_decode (
        .addr_i      (win_addr),
        .in_window_o (win_in_window),
        .word_addr_o (win_word_addr)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        word_addr_d = word_addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        case (state_q)
            StIdle: begin
                if (any_valid) begin
                    grant_d     = win_id;
                    word_addr_d = win_word_addr;
                    wdata_d     = (win_id == MasterAux) ? m1_wdata : m0_wdata;
                    wstrb_d     = (win_id == MasterAux) ? m1_wstrb : m0_wstrb;
                    state_d     = win_in_window ? StAccess : StFault;
                end
            end
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            StFault:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            grant_q     <= MasterCpu;
            word_addr_q <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            word_addr_q <= word_addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    logic        resp_active;
    logic        resp_ok;
    logic [31:0] resp_rdata;

    // Outputs are gated by reset so an aborted transaction neither writes nor responds.
    assign resp_active = ~reset & ((state_q == StResp) | (state_q == StFault));
    assign resp_ok     = (state_q == StResp);
    assign resp_rdata  = resp_ok ? bram_rdata : 32'h0;

    assign m0_ready = resp_active & (grant_q == MasterCpu);
    assign m0_rdata = m0_ready ? resp_rdata : 32'h0;
    assign m0_fault = m0_ready & ~resp_ok;

    assign m1_ready = resp_active & (grant_q == MasterAux);
    assign m1_rdata = m1_ready ? resp_rdata : 32'h0;
    assign m1_fault = m1_ready & ~resp_ok;

    assign bram_addr  = word_addr_q;
    assign bram_wdata = wdata_q;
    assign bram_wmask = (~reset && state_q == StAccess) ? wstrb_q : 4'b0000;

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_bram_bus_arbiter.sv
// Scoreboard bench for bram_bus_arbiter: a transaction-level model predicts grant order,
// response cycle and data; a monitor checks every ready pulse against the queue.
module tb_bram_bus_arbiter;

    localparam int unsigned BRAM_WORDS = 8192;
    localparam int unsigned AW         = 13;
    localparam logic [31:0] BASE       = 32'h0000_0000;

    logic          clk;
    logic          reset;
    logic          m0_valid, m1_valid;
    logic [31:0]   m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]    m0_wstrb, m1_wstrb;
    logic          m0_ready, m1_ready, m0_fault, m1_fault;
    logic [31:0]   m0_rdata, m1_rdata;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_wdata;
    logic [3:0]    bram_wmask;
    logic [31:0]   bram_rdata;
    logic          busy;

    bram_bus_arbiter #(
        .BRAM_WORDS      (BRAM_WORDS),
        .BRAM_ADDR_WIDTH (AW),
        .BRAM_BASE       (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_valid   (m0_valid),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_wstrb   (m0_wstrb),
        .m0_ready   (m0_ready),
        .m0_rdata   (m0_rdata),
        .m0_fault   (m0_fault),
        .m1_valid   (m1_valid),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_wstrb   (m1_wstrb),
        .m1_ready   (m1_ready),
        .m1_rdata   (m1_rdata),
        .m1_fault   (m1_fault),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_wmask (bram_wmask),
        .bram_rdata (bram_rdata),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-first synchronous BRAM.
    logic [31:0] bram_mem [BRAM_WORDS];
    always @(posedge clk) begin
        bram_rdata <= bram_mem[bram_addr];
        for (int b = 0; b < 4; b++) begin
            if (bram_wmask[b]) bram_mem[bram_addr][8*b +: 8] = bram_wdata[8*b +: 8];
        end
    end

    typedef struct {
        bit          id;
        logic [31:0] rdata;
        bit          fault;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        me;
    logic [31:0] ref_mem [BRAM_WORDS];
    bit          rr_last = 1'b1;
    int          n_vec = 0;
    int          n_fail = 0;
    int          n_wr_exp = 0;
    int          n_wr_seen = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic bit in_win(logic [31:0] a);
        longint unsigned lo = longint'(BASE);
        longint unsigned hi = longint'(BASE) + longint'(BRAM_WORDS) * 4;
        return (longint'(a) >= lo) && (longint'(a) < hi);
    endfunction

    function automatic bit tie_winner();
`ifdef ARB_ROUND_ROBIN_EN
        return ~rr_last;
`else
        return 1'b0;
`endif
    endfunction

    // One granted transaction starting in IDLE cycle t; returns the next IDLE cycle.
    function automatic int model_txn(bit id, logic [31:0] a, logic [31:0] wd, logic [3:0] s,
                                     int t);
        exp_t e;
        int   w;
        e.id = id;
        if (in_win(a)) begin
            w       = int'((a - BASE) >> 2);
            e.rdata = ref_mem[w];
            e.fault = 1'b0;
            e.cyc   = t + 2;
            for (int b = 0; b < 4; b++) begin
                if (s[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
            end
            if (s != 4'b0) n_wr_exp++;
        end else begin
            e.rdata = 32'h0;
            e.fault = 1'b1;
            e.cyc   = t + 1;
        end
        rr_last = id;
        exp_q.push_back(e);
        return e.cyc + 1;
    endfunction

    // Monitor: every ready pulse pops one expected response.
    always @(negedge clk) begin
        if (!reset) begin
            if (bram_wmask != 4'b0) n_wr_seen++;
            if (m0_ready && m1_ready) begin
                chk("both_ready", 32'(m1_ready), 32'(1'b0));
            end else if (m0_ready || m1_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 32'(1'b1), 32'(1'b0));
                end else begin
                    me = exp_q.pop_front();
                    chk("grant_id", 32'(m1_ready), 32'(me.id));
                    chk("rdata", m1_ready ? m1_rdata : m0_rdata, me.rdata);
                    chk("fault", 32'(m1_ready ? m1_fault : m0_fault), 32'(me.fault));
                    chk("ready_cycle", 32'(cyc), 32'(me.cyc));
                    chk("idle_master_out", m1_ready ? (m0_rdata | 32'(m0_fault))
                                                    : (m1_rdata | 32'(m1_fault)), 32'h0);
                end
            end
        end
    end

    task automatic run_batch(bit v0, bit v1, logic [31:0] a0, logic [31:0] a1,
                             logic [31:0] w0, logic [31:0] w1, logic [3:0] s0, logic [3:0] s1);
        int          t;
        bit          first;
        bit          p0, p1;
        int          k;
        logic [31:0] fa;
        logic [31:0] fw;
        logic [3:0]  fs;
        t     = cyc;
        first = (v0 && v1) ? tie_winner() : v1;
        fa    = first ? a1 : a0;
        fw    = first ? w1 : w0;
        fs    = first ? s1 : s0;
        t     = model_txn(first, fa, fw, fs, t);
        if (v0 && v1) t = model_txn(~first, first ? a0 : a1, first ? w0 : w1, first ? s0 : s1, t);
        m0_valid = v0; m0_addr = a0; m0_wdata = w0; m0_wstrb = s0;
        m1_valid = v1; m1_addr = a1; m1_wdata = w1; m1_wstrb = s1;
        p0 = 1'b0; p1 = 1'b0; k = 0;
        while ((m0_valid || m1_valid) && k < 30) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                if (in_win(fa)) begin
                    chk("access_addr", 32'(bram_addr), (fa - BASE) >> 2);
                    chk("access_wmask", 32'(bram_wmask), 32'(fs));
                    if (fs != 4'b0) chk("access_wdata", bram_wdata, fw);
                end else begin
                    chk("fault_wmask", 32'(bram_wmask), 32'h0);
                end
            end
            if (p0) m0_valid = 1'b0;
            if (p1) m1_valid = 1'b0;
            p0 = m0_ready;
            p1 = m1_ready;
        end
        if (k >= 30) begin
            chk("batch_timeout", 32'(k), 32'(29));
            m0_valid = 1'b0;
            m1_valid = 1'b0;
            exp_q.delete();
        end
    endtask

    // Both masters hold read requests continuously for four grants.
    task automatic run_stream();
        int t;
        int grants;
        int k;
        bit id;
        t = cyc;
        for (int i = 0; i < 4; i++) begin
            id = tie_winner();
            t  = model_txn(id, id ? 32'h0000_0080 : 32'h0000_0040, 32'h0, 4'b0, t);
        end
        m0_valid = 1'b1; m0_addr = 32'h0000_0040; m0_wdata = '0; m0_wstrb = 4'b0;
        m1_valid = 1'b1; m1_addr = 32'h0000_0080; m1_wdata = '0; m1_wstrb = 4'b0;
        grants = 0; k = 0;
        while (grants < 4 && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (m0_ready || m1_ready) grants++;
        end
        if (k >= 40) begin
            chk("stream_timeout", 32'(grants), 32'(4));
            exp_q.delete();
        end
        @(posedge clk); #1;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return $urandom | 32'h0000_8000;
        return BASE + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] v;
        int          bad;
        bit          v0, v1;
        logic [31:0] a0, a1, w0, w1;
        logic [3:0]  s0, s1;

        for (int i = 0; i < int'(BRAM_WORDS); i++) begin
            v = $urandom;
            bram_mem[i] = v;
            ref_mem[i]  = v;
        end
        bram_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4]  = 32'hDEAD_BEEF;

        reset = 1'b1;
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b0;
        rr_last = 1'b1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'({m0_ready, m1_ready}), 32'h0);
        chk("rst_fault", 32'({m0_fault, m1_fault}), 32'h0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        chk("rst_wmask", 32'(bram_wmask), 32'h0);
        chk("rst_addr", 32'(bram_addr), 32'h0);
        chk("rst_wdata", bram_wdata, 32'h0);

        run_batch(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 32'h0, 4'b0000, 4'b0000);
        run_batch(1'b0, 1'b1, 32'h0, 32'h0000_0020, 32'h0, 32'h1234_5678, 4'b0000, 4'b0011);
        run_batch(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0, 32'h0, 4'b0000, 4'b0000);
        chk("halfword_merge", ref_mem[8][15:0], 32'h5678);
        run_batch(1'b1, 1'b0, 32'h0000_8000, 32'h0, 32'hFFFF_FFFF, 32'h0, 4'b1111, 4'b0000);
        run_batch(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 32'h0, 4'b1111, 4'b0000);
        run_stream();

        // Reset during the ACCESS cycle of an m0 write: no write, no ready.
        m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wdata = 32'hA5A5_5A5A; m0_wstrb = 4'b1111;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        chk("abort_wmask", 32'(bram_wmask), 32'h0);
        chk("abort_ready", 32'(m0_ready), 32'h0);
        @(posedge clk); #1;
        reset    = 1'b0;
        m0_valid = 1'b0;
        rr_last  = 1'b1;
        chk("abort_idle", 32'(busy), 32'h0);
        chk("abort_word", bram_mem[64], ref_mem[64]);
        run_batch(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hA5A5_5A5A, 32'h0, 4'b1111, 4'b0000);

        for (int i = 0; i < 150; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            a0 = rand_addr();
            a1 = rand_addr();
            w0 = $urandom;
            w1 = $urandom;
            s0 = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            s1 = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            run_batch(v0, v1, a0, a1, w0, w1, s0, s1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        chk("write_count", 32'(n_wr_seen), 32'(n_wr_exp));
        bad = 0;
        for (int i = 0; i < int'(BRAM_WORDS); i++) begin
            if (bram_mem[i] !== ref_mem[i]) bad++;
        end
        chk("mem_words_differing", 32'(bad), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
